// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM states
// and the alignment check.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_R,
    RESP
  } lsu_state_t;

  // Reserved size 2'b11 is handled as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  is_misaligned = 1'b0;
      SIZE_H:  is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store strobes and lane-replicated
// write data, plus load field extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      size,
  input  logic [1:0]      off,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] wdata_lane,
  output logic [XLEN-1:0] rdata_ext
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte      = rdata[{off, 3'b000} +: 8];
    rhalf      = rdata[{off[1], 4'b0000} +: 16];
    wstrb      = '1;
    wdata_lane = wdata;
    rdata_ext  = rdata;
    case (size)
      SIZE_B: begin
        wstrb      = 4'b0001 << off;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{rbyte[7] & ~is_unsigned}}, rbyte};
      end
      // Only off[1] picks the half; a stray off[0] is dropped here.
      SIZE_H: begin
        wstrb      = 4'b0011 << {off[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{rhalf[15] & ~is_unsigned}}, rhalf};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: one load/store at a time, valid/ready request to
// memory, aligned/extended load result pulse. Optional macro LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  output logic            dmem_valid,
  input  logic            dmem_ready,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err,
  output logic            stall
);

  lsu_state_t      state, state_nxt;
  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic            trap;
  logic            err_q;
  logic [3:0]      strb;
  logic [XLEN-1:0] wlane;
  logic [XLEN-1:0] rext;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap     = is_misaligned(req_size, req_addr[1:0]);
  assign resp_err = err_q;
`else
  assign trap     = 1'b0;
  assign resp_err = 1'b0;
`endif

  lsu_align #(.XLEN(XLEN)) u_align (
    .size        (size_q),
    .off         (addr_q[1:0]),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rdata       (dmem_rdata),
    .wstrb       (strb),
    .wdata_lane  (wlane),
    .rdata_ext   (rext)
  );

  assign dmem_we    = we_q;
  assign dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign dmem_wdata = wlane;
  assign dmem_wstrb = we_q ? strb : '0;

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    dmem_valid = 1'b0;
    resp_valid = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) state_nxt = trap ? RESP : ISSUE;
      end
      ISSUE: begin
        dmem_valid = 1'b1;
        stall      = 1'b1;
        if (dmem_ready) state_nxt = we_q ? RESP : WAIT_R;
      end
      WAIT_R: begin
        stall = 1'b1;
        if (dmem_rvalid) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      resp_data <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        we_q      <= req_we;
        addr_q    <= req_addr;
        wdata_q   <= req_wdata;
        size_q    <= req_size;
        uns_q     <= req_unsigned;
        resp_data <= '0;
        err_q     <= trap;
      end
      if (state == WAIT_R && dmem_rvalid) resp_data <= rext;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven bench for load_store_unit with a response scoreboard and a
// bench-side memory that applies configurable ready/rvalid delays.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        dmem_valid;
  logic        dmem_ready;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        stall;

  load_store_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .dmem_valid   (dmem_valid),
    .dmem_ready   (dmem_ready),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_wstrb   (dmem_wstrb),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .stall        (stall)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_data;
    logic        mis;
    int unsigned rwait;
    int unsigned vwait;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int unsigned cyc;
  } exp_t;

  localparam int NV = 13;
  vec_t        vt[NV];
  exp_t        sbq[$];
  exp_t        mon_e;
  int unsigned cyc;
  int          ntests;
  int          nfail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("resp_data", resp_data, mon_e.data);
        chk("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
        chk("resp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic run_txn(input vec_t v);
    exp_t e;
    bit   tr;
    tr = TRAP && v.mis;
    @(posedge clk); #1;
    req_valid    = 1'b1;
    req_we       = v.we;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    req_size     = v.size;
    req_unsigned = v.uns;
    @(negedge clk);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
    chk("idle_stall", {31'd0, stall}, 32'd1);
    e.err  = tr;
    e.data = (tr || v.we) ? 32'd0 : v.e_data;
    if (tr)        e.cyc = cyc + 1;
    else if (v.we) e.cyc = cyc + 2 + v.rwait;
    else           e.cyc = cyc + 3 + v.rwait + v.vwait;
    sbq.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_size  = 2'($urandom_range(0, 3));
    if (!tr) begin
      for (int unsigned n = 0; n <= v.rwait; n++) begin
        @(negedge clk);
        chk("issue_valid", {31'd0, dmem_valid}, 32'd1);
        chk("issue_addr", dmem_addr, v.e_addr);
        chk("issue_wstrb", {28'd0, dmem_wstrb}, {28'd0, v.e_strb});
        chk("issue_we", {31'd0, dmem_we}, {31'd0, v.we});
        if (v.we) chk("issue_wdata", dmem_wdata, v.e_wdata);
        chk("issue_stall", {31'd0, stall}, 32'd1);
        chk("issue_ready", {31'd0, req_ready}, 32'd0);
        dmem_ready = (n == v.rwait);
        @(posedge clk); #1;
        dmem_ready = 1'b0;
      end
      if (!v.we) begin
        for (int unsigned n = 0; n < v.vwait; n++) begin
          @(negedge clk);
          chk("wait_stall", {31'd0, stall}, 32'd1);
          chk("wait_dvalid", {31'd0, dmem_valid}, 32'd0);
        end
        @(negedge clk);
        dmem_rvalid = 1'b1;
        dmem_rdata  = v.rdata;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        dmem_rdata  = $urandom;
      end
    end
    @(negedge clk);
    chk("resp_pulse", {31'd0, resp_valid}, 32'd1);
    chk("resp_stall", {31'd0, stall}, 32'd0);
    chk("resp_reqready", {31'd0, req_ready}, 32'd0);
    chk("resp_dvalid", {31'd0, dmem_valid}, 32'd0);
    @(negedge clk);
    chk("pulse_end", {31'd0, resp_valid}, 32'd0);
    chk("back_idle", {31'd0, req_ready}, 32'd1);
    chk("sb_drained", sbq.size(), 32'd0);
  endtask

  initial begin
    ntests = 0;
    nfail  = 0;
    //          we    addr          wdata         size   uns   rdata         e_addr        e_strb   e_wdata       e_data        mis  rw vw
    vt[0]  = '{1'b1, 32'h0000_1003, 32'h0000_00AB, 2'b00, 1'b0, 32'h0,        32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 32'h0,        1'b0, 0, 0};
    vt[1]  = '{1'b1, 32'h0000_1003, 32'h0000_00AB, 2'b00, 1'b0, 32'h0,        32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 32'h0,        1'b0, 3, 0};
    vt[2]  = '{1'b0, 32'h0000_2001, 32'h0,         2'b00, 1'b0, 32'h1234_F600, 32'h0000_2000, 4'b0000, 32'h0,        32'hFFFF_FFF6, 1'b0, 0, 0};
    vt[3]  = '{1'b0, 32'h0000_2001, 32'h0,         2'b00, 1'b1, 32'h1234_F600, 32'h0000_2000, 4'b0000, 32'h0,        32'h0000_00F6, 1'b0, 0, 0};
    vt[4]  = '{1'b0, 32'h0000_2002, 32'h0,         2'b01, 1'b0, 32'h8001_7FFF, 32'h0000_2000, 4'b0000, 32'h0,        32'hFFFF_8001, 1'b0, 0, 2};
    vt[5]  = '{1'b0, 32'h0000_2002, 32'h0,         2'b01, 1'b1, 32'h8001_7FFF, 32'h0000_2000, 4'b0000, 32'h0,        32'h0000_8001, 1'b0, 1, 0};
    vt[6]  = '{1'b1, 32'h0000_2002, 32'h1234_5678, 2'b01, 1'b0, 32'h0,        32'h0000_2000, 4'b1100, 32'h5678_5678, 32'h0,        1'b0, 0, 0};
    vt[7]  = '{1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0,        32'h0000_4000, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0, 0, 0};
    vt[8]  = '{1'b0, 32'h0000_4004, 32'h0,         2'b10, 1'b1, 32'h8765_4321, 32'h0000_4004, 4'b0000, 32'h0,        32'h8765_4321, 1'b0, 0, 1};
    vt[9]  = '{1'b1, 32'h0000_3002, 32'h1122_3344, 2'b10, 1'b0, 32'h0,        32'h0000_3000, 4'b1111, 32'h1122_3344, 32'h0,        1'b1, 0, 0};
    vt[10] = '{1'b0, 32'h0000_5003, 32'h0,         2'b00, 1'b0, 32'h7F00_0000, 32'h0000_5000, 4'b0000, 32'h0,        32'h0000_007F, 1'b0, 0, 0};
    vt[11] = '{1'b1, 32'h0000_6000, 32'hCAFE_F00D, 2'b11, 1'b0, 32'h0,        32'h0000_6000, 4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0, 0, 0};
    vt[12] = '{1'b0, 32'h0000_2001, 32'h0,         2'b01, 1'b0, 32'hABCD_9234, 32'h0000_2000, 4'b0000, 32'h0,        32'hFFFF_9234, 1'b1, 0, 0};

    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    req_size     = '0;
    req_unsigned = 1'b0;
    dmem_ready   = 1'b0;
    dmem_rvalid  = 1'b0;
    dmem_rdata   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_dmem_valid", {31'd0, dmem_valid}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_wstrb", {28'd0, dmem_wstrb}, 32'd0);

    for (int i = 0; i < NV; i++) run_txn(vt[i]);

    // Reset while waiting for read data; the late rvalid must not produce a response.
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0000_7000;
    req_size  = 2'b10;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    dmem_ready = 1'b1;
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    @(negedge clk);
    chk("waitr_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_ready", {31'd0, req_ready}, 32'd1);
    chk("postrst_stall", {31'd0, stall}, 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h5555_AAAA;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("late_rvalid_resp", {31'd0, resp_valid}, 32'd0);
      chk("late_rvalid_ready", {31'd0, req_ready}, 32'd1);
      chk("late_rvalid_dvalid", {31'd0, dmem_valid}, 32'd0);
    end
    chk("final_sb_empty", sbq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
